mc_datapath: RTL

Multicycle MIPS-subset core: datapath, 32×32 register file and control FSM in one block, sharing a single memory port for instruction fetch and data access. It is the next generation of the single-cycle datapath. It spreads each instruction over 3–5 states, uses a variable-latency memory handshake instead of zero-wait separate memories, and adds a trap state for illegal encodings. It sits between the top level and a unified instruction/data memory.

---
 rtl/mc_datapath.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mc_datapath
// Brief    : Multicycle MIPS-subset core (datapath, 32x32 register file and
//            control FSM) on a single handshaked instruction/data memory port.
//            Optional bne decode enabled by defining MC_BNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [3:0]  state,
    output logic        instr_retired,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_rf [0:31];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [2:0]  w_alu_ctl;
    logic        w_funct_ok;
    logic [31:0] w_alu_res;
    logic        w_take;
    logic        w_unused_shamt;

    assign w_op           = r_ir[31:26];
    assign w_rs           = r_ir[25:21];
    assign w_rt           = r_ir[20:16];
    assign w_rd           = r_ir[15:11];
    assign w_funct        = r_ir[5:0];
    assign w_simm         = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_unused_shamt = ^r_ir[10:6];

    always_comb begin
        w_alu_ctl  = c_ALU_ADD;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'b100000: w_alu_ctl = c_ALU_ADD;
            6'b100010: w_alu_ctl = c_ALU_SUB;
            6'b100100: w_alu_ctl = c_ALU_AND;
            6'b100101: w_alu_ctl = c_ALU_OR;
            6'b101010: w_alu_ctl = c_ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_res = r_a + r_b;
        case (w_alu_ctl)
            c_ALU_SUB: w_alu_res = r_a - r_b;
            c_ALU_AND: w_alu_res = r_a & r_b;
            c_ALU_OR:  w_alu_res = r_a | r_b;
            c_ALU_SLT: w_alu_res = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
            default:   w_alu_res = r_a + r_b;
        endcase
    end

    // Only beq (and bne when enabled) can reach BRANCH, so the opcode picks the sense.
`ifdef MC_BNE_EN
    assign w_take = (w_op == c_OP_BNE) ? (r_a != r_b) : (r_a == r_b);
`else
    assign w_take = (r_a == r_b);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_aluout <= r_pc + (w_simm << 2);
                    case (w_op)
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_RTYPE:       r_state <= S_EXEC;
                        c_OP_BEQ:         r_state <= S_BRANCH;
`ifdef MC_BNE_EN
                        c_OP_BNE:         r_state <= S_BRANCH;
`endif
                        c_OP_ADDI:        r_state <= S_ADDIEX;
                        c_OP_J:           r_state <= S_JUMP;
                        default:          r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    r_aluout <= r_a + w_simm;
                    r_state  <= (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        r_mdr   <= mem_rdata;
                        r_state <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
                    r_state <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_ready) r_state <= S_FETCH;
                end
                S_EXEC: begin
                    if (w_funct_ok) begin
                        r_aluout <= w_alu_res;
                        r_state  <= S_ALUWB;
                    end else begin
                        r_state  <= S_TRAP;
                    end
                end
                S_ALUWB: begin
                    if (w_rd != 5'd0) r_rf[w_rd] <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_BRANCH: begin
                    if (w_take) r_pc <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_ADDIEX: begin
                    r_aluout <= r_a + w_simm;
                    r_state  <= S_ADDIWB;
                end
                S_ADDIWB: begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign mem_we    = (r_state == S_MEMWR);
    assign mem_addr  = (r_state == S_FETCH) ? r_pc : r_aluout;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign state     = r_state;
    assign halted    = (r_state == S_TRAP);
    assign instr_retired = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                           (r_state == S_ADDIWB) || (r_state == S_BRANCH) ||
                           (r_state == S_JUMP) || ((r_state == S_MEMWR) && mem_ready);

endmodule
`default_nettype wire
